// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges in-order WB writes with out-of-order
// mul/div results through a small FIFO, with WAW cancellation and bypass.
module wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        md_valid,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]       buf_waddr_q [DEPTH];
  logic [4:0]       buf_waddr_d [DEPTH];
  logic [31:0]      buf_wdata_q [DEPTH];
  logic [31:0]      buf_wdata_d [DEPTH];
  logic [DEPTH-1:0] buf_valid_q, buf_valid_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic pipe_sel, md_acc, md_live, buf_empty;
  logic head_valid, head_kill, head_emit, pop, bypass, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pipe_sel   = pipe_we && (pipe_waddr != '0);
    md_ready   = (count_q != FULL_CNT);
    md_acc     = md_valid && md_ready;
    md_live    = md_acc && (md_waddr != '0) && !(pipe_sel && (md_waddr == pipe_waddr));
    buf_empty  = (count_q == '0);
    head_valid = buf_valid_q[rd_ptr_q];
    head_kill  = pipe_sel && (buf_waddr_q[rd_ptr_q] == pipe_waddr);
    // A dead head (stale or killed this cycle) is dropped even while the pipe owns the port.
    pop        = !buf_empty && (!head_valid || head_kill || !pipe_sel);
    head_emit  = !buf_empty && head_valid && !pipe_sel;
    bypass     = md_live && !pipe_sel && buf_empty;
    push       = md_live && !bypass;
  end

  always_comb begin
    buf_waddr_d = buf_waddr_q;
    buf_wdata_d = buf_wdata_q;
    buf_valid_d = buf_valid_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;

    if (pipe_sel) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (head_emit) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = buf_waddr_q[rd_ptr_q];
      rf_wdata_d = buf_wdata_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = md_waddr;
      rf_wdata_d = md_wdata;
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pipe_sel && (buf_waddr_q[i] == pipe_waddr)) buf_valid_d[i] = 1'b0;
    end

    if (pop) begin
      buf_valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d              = ptr_inc(rd_ptr_q);
    end

    if (push) begin
      buf_waddr_d[wr_ptr_q] = md_waddr;
      buf_wdata_d[wr_ptr_q] = md_wdata;
      buf_valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_waddr_q <= '{default: '0};
      buf_wdata_q <= '{default: '0};
      buf_valid_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      buf_waddr_q <= buf_waddr_d;
      buf_wdata_q <= buf_wdata_d;
      buf_valid_q <= buf_valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (buf_valid_q[i]) pend_mask[buf_waddr_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
